// File: rtl/wrap_event_monitor.sv
// wrap_event_monitor
// Watches a free-running upstream counter and counts wrap events, where a
// wrap is the count going from all-ones to zero. The wrap count saturates
// at all-ones. A non-zero threshold makes the FSM enter MATCHED; once there
// it stays until clr or reset.
// Optional feature: define WRAP_SEQ_CHECK_EN to compile in sequence
// checking. With it, any step other than +1 or hold raises a sticky seq_err.
// In TRACK such a step also forces a resync through SYNC.
// Debug: dbg_state exposes the FSM state (0 = SYNC, 1 = TRACK, 2 = MATCHED).
module wrap_event_monitor #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic [EVT_W-1:0] thresh,
  output logic [EVT_W-1:0] wrap_cnt,
  output logic             wrap_pulse,
  output logic             match,
  output logic             seq_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_MATCHED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q;
  logic [EVT_W-1:0] wrap_cnt_q, wrap_cnt_d, wrap_cnt_inc;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             wrap_det;
  logic             hit;
  logic             seq_bad;

  // A wrap is the previous sample at all-ones followed by zero now.
  assign wrap_det     = (prev_q == '1) && (cnt_in == '0);
  // The wrap count saturates rather than rolling over to zero.
  assign wrap_cnt_inc = (wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + EVT_W'(1);
  // Using >= also covers a threshold that is already passed (for example,
  // thresh lowered): the next wrap then enters MATCHED.
  assign hit          = (thresh != '0) && (wrap_cnt_inc >= thresh);

`ifdef WRAP_SEQ_CHECK_EN
  logic [CNT_W-1:0] prev_inc;
  logic             seq_err_q, seq_err_d;

  assign prev_inc = prev_q + CNT_W'(1);
  // A legal step is +1 (mod 2^CNT_W) or a hold; anything else is an error.
  assign seq_bad  = (cnt_in != prev_inc) && (cnt_in != prev_q);
  assign seq_err  = seq_err_q;
`else
  assign seq_bad  = 1'b0;
  assign seq_err  = 1'b0;
`endif

  // Compute the next state and next outputs; clr overrides everything else.
  always_comb begin
    state_d      = state_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
`ifdef WRAP_SEQ_CHECK_EN
    seq_err_d    = seq_err_q;
`endif
    if (clr) begin
      state_d    = ST_SYNC;
      wrap_cnt_d = '0;
`ifdef WRAP_SEQ_CHECK_EN
      seq_err_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_SYNC: state_d = ST_TRACK;
        ST_TRACK: begin
          if (seq_bad) begin
`ifdef WRAP_SEQ_CHECK_EN
            seq_err_d = 1'b1;
`endif
            state_d   = ST_SYNC;
          end else if (wrap_det) begin
            wrap_cnt_d   = wrap_cnt_inc;
            wrap_pulse_d = 1'b1;
            if (hit) state_d = ST_MATCHED;
          end
        end
        ST_MATCHED: begin
`ifdef WRAP_SEQ_CHECK_EN
          if (seq_bad) seq_err_d = 1'b1;
`endif
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // Register the state and the event outputs; prev_q samples cnt_in on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SYNC;
      prev_q       <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
`ifdef WRAP_SEQ_CHECK_EN
      seq_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_q       <= cnt_in;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
`ifdef WRAP_SEQ_CHECK_EN
      seq_err_q    <= seq_err_d;
`endif
    end
  end

  assign wrap_cnt   = wrap_cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign match      = (state_q == ST_MATCHED);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_wrap_event_monitor.sv
// Testbench for wrap_event_monitor: directed count sequences checked against
// a behavioural model and a few hand-computed literal expectations.
module tb_wrap_event_monitor;

  localparam int CNT_W = 4;
  localparam int EVT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int EVT_MAX = (1 << EVT_W) - 1;
`ifdef WRAP_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] cnt_in = '0;
  logic             clr = 1'b0;
  logic [EVT_W-1:0] thresh = '0;
  logic [EVT_W-1:0] wrap_cnt;
  logic             wrap_pulse;
  logic             match;
  logic             seq_err;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  wrap_event_monitor #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .clr(clr), .thresh(thresh),
    .wrap_cnt(wrap_cnt), .wrap_pulse(wrap_pulse), .match(match),
    .seq_err(seq_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;
  int c = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the observable meaning directly: how many wraps have been
  // counted, whether the threshold has been reached, and whether the previous
  // sample is trustworthy ("live") enough to judge a wrap or a jump.
  int m_wraps = 0;
  bit m_pulse = 0, m_matched = 0, m_err = 0, m_live = 0;
  int m_prev = 0;
  bit m_is_wrap, m_jump;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wraps = 0; m_pulse = 0; m_matched = 0; m_err = 0; m_live = 0; m_prev = 0;
    end else begin
      m_is_wrap = (m_prev == CNT_MOD - 1) && (int'(cnt_in) == 0);
      m_jump    = (int'(cnt_in) != (m_prev + 1) % CNT_MOD) && (int'(cnt_in) != m_prev);
      m_pulse   = 0;
      if (clr) begin
        m_wraps = 0; m_matched = 0; m_err = 0; m_live = 0;
      end else if (m_matched) begin
        if (SEQ_EN && m_jump) m_err = 1;
      end else if (!m_live) begin
        m_live = 1;
      end else if (SEQ_EN && m_jump) begin
        m_err = 1; m_live = 0;
      end else if (m_is_wrap) begin
        m_wraps = (m_wraps < EVT_MAX) ? m_wraps + 1 : EVT_MAX;
        m_pulse = 1;
        if (thresh != 0 && m_wraps >= int'(thresh)) m_matched = 1;
      end
      m_prev = int'(cnt_in);
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wrap_cnt", int'(wrap_cnt), m_wraps);
      chk("wrap_pulse", int'(wrap_pulse), int'(m_pulse));
      chk("match", int'(match), int'(m_matched));
      chk("seq_err", int'(seq_err), int'(m_err));
      if (wrap_pulse) pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; returns 1 ns after the falling edge, when the compare has run.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      cnt_in = CNT_W'(c);
      tick();
      c = (c + 1) % CNT_MOD;
    end
  endtask

  task automatic run_to(input int v);
    for (int i = 0; i < CNT_MOD && c != v; i++) run_count(1);
  endtask

  task automatic pulse_clr();
    cnt_in = CNT_W'(c);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    c = (c + 1) % CNT_MOD;
  endtask

  int p0;

  initial begin
    // Reset with the upstream counter mid-count.
    rst_n = 1'b0; cnt_in = 4'd7; c = 7; thresh = '0;
    #23;
    cmp_en = 1'b1;
    chk("reset_wrap_cnt", int'(wrap_cnt), 0);
    chk("reset_pulse", int'(wrap_pulse), 0);
    chk("reset_match", int'(match), 0);
    chk("reset_state", int'(dbg_state), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Free-running count with the threshold disabled: 48 samples from 7 contain three 15->0 steps.
    p0 = pulses;
    run_count(48);
    chk("free_wrap_cnt", int'(wrap_cnt), 3);
    chk("free_pulses", pulses - p0, 3);
    chk("free_match", int'(match), 0);

    // clr coincides with a 15->0 step: the wrap is swallowed.
    run_to(0);
    pulse_clr();
    chk("clr_on_wrap_cnt", int'(wrap_cnt), 0);
    chk("clr_on_wrap_pulse", int'(wrap_pulse), 0);

    // thresh = 3: match appears after the third wrap and the count then freezes.
    thresh = 8'd3;
    p0 = pulses;
    run_count(64);
    chk("thr3_match", int'(match), 1);
    chk("thr3_wrap_cnt", int'(wrap_cnt), 3);
    chk("thr3_pulses", pulses - p0, 3);

    // clr out of MATCHED, then the first wrap afterwards counts as 1.
    pulse_clr();
    chk("clr_match", int'(match), 0);
    chk("clr_wrap_cnt", int'(wrap_cnt), 0);
    chk("clr_state_sync", int'(dbg_state), 0);
    thresh = '0;
    run_to(1);
    chk("after_clr_first_wrap", int'(wrap_cnt), 1);

    // Threshold lowered below the current count: the next wrap enters MATCHED.
    run_count(16);
    thresh = 8'd1;
    run_count(16);
    chk("late_thresh_match", int'(match), 1);
    chk("late_thresh_cnt", int'(wrap_cnt), 3);

    // Jump 5 -> 9 while tracking.
    pulse_clr();
    thresh = '0;
    run_to(1);
    run_to(5);
    run_count(1);
    c = 9;
    run_count(1);
    chk("jump_seq_err", int'(seq_err), SEQ_EN ? 1 : 0);
    chk("jump_wrap_cnt", int'(wrap_cnt), 1);
    run_count(32);
    chk("jump_resume_cnt", int'(wrap_cnt), 3);

    // Saturation: 257 wraps from zero end at the all-ones count, and every wrap pulses.
    pulse_clr();
    thresh = '0;
    p0 = pulses;
    for (int i = 0; i < 257 * CNT_MOD + 40 && (pulses - p0) < 257; i++) run_count(1);
    chk("sat_pulses", pulses - p0, 257);
    chk("sat_wrap_cnt", int'(wrap_cnt), 255);
    p0 = pulses;
    run_count(32);
    chk("sat_hold_cnt", int'(wrap_cnt), 255);
    chk("sat_hold_pulses", pulses - p0, 2);

    // Asynchronous reset during a wrap_pulse cycle clears it immediately.
    for (int i = 0; i < 2 * CNT_MOD && !wrap_pulse; i++) run_count(1);
    chk("pre_reset_pulse", int'(wrap_pulse), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", int'(wrap_pulse), 0);
    chk("async_rst_cnt", int'(wrap_cnt), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_count(20);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
